y86_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the Simple y86 CPU. It steps each instruction through the FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE phases, and drives the enables for the PC register, register file, ALU/condition codes and both memory ports. It owns the y86 status code and halts the core on halt, invalid-instruction and address/timeout faults. It sits between the instruction decoder and the datapath (PC register, RegFile, ALU, data memory).

---
 rtl/y86_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle control sequencer for the Simple y86 core: phase FSM, datapath enables, status code and fault halting.
// Optional performance counters are compiled in when Y86_PERF_CNT_EN is defined.
module y86_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] icode,
  input  logic       cnd,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic       imem_err,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  input  logic       dmem_err,
  output logic       ir_load,
  output logic       rf_rd_en,
  output logic       alu_en,
  output logic       cc_load,
  output logic       rf_we_e,
  output logic       rf_we_m,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [2:0] stat,
  output logic       halted
`ifdef Y86_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [2:0] S_BOOT      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPDATE  = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Timeout fires in the wait cycle that would bring the counter up to the limit.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] stat_q, stat_d;
  logic       halted_q, halted_d;
  logic [7:0] wait_q, wait_d;

  function automatic logic uses_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  function automatic logic mem_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  function automatic logic writes_vale(input logic [3:0] ic, input logic c);
    return (ic == 4'h3) || (ic == 4'h6) || (ic == 4'h8) || (ic == 4'h9) ||
           (ic == 4'hA) || (ic == 4'hB) || ((ic == 4'h2) && c);
  endfunction

  function automatic logic [1:0] next_pc_src(input logic [3:0] ic, input logic c);
    if ((ic == 4'h8) || ((ic == 4'h7) && c)) return 2'd1;
    if (ic == 4'h9) return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_DECODE;
          end
        end else if (wait_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else if (icode > 4'hB) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (uses_mem(icode)) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
    // HALT is only left through reset, so the flag simply tracks entry into it.
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      wait_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    imem_req = (state_q == S_FETCH);
    ir_load  = (state_q == S_FETCH) && imem_ack && !imem_err;
    rf_rd_en = (state_q == S_DECODE);
    alu_en   = (state_q == S_EXECUTE);
    cc_load  = (state_q == S_EXECUTE) && (icode == 4'h6);
    dmem_req = (state_q == S_MEMORY);
    dmem_we  = (state_q == S_MEMORY) && mem_write(icode);
    rf_we_e  = (state_q == S_WRITEBACK) && writes_vale(icode, cnd);
    rf_we_m  = (state_q == S_WRITEBACK) && ((icode == 4'h5) || (icode == 4'hB));
    pc_we    = (state_q == S_PCUPDATE);
    pc_sel   = (state_q == S_PCUPDATE) ? next_pc_src(icode, cnd) : 2'd0;
    stat     = stat_q;
    halted   = halted_q;
  end

`ifdef Y86_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q + ((state_q == S_PCUPDATE) ? 32'd1 : 32'd0);
    cycle_cnt_d   = cycle_cnt_q +
                    (((state_q != S_BOOT) && (state_q != S_HALT)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 32'd0;
      cycle_cnt_q   <= 32'd0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: instruction flows, PC source selection, faults, timeout and reset.
module tb_y86_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] icode;
  logic       cnd;
  logic       imem_req, imem_ack, imem_err;
  logic       dmem_req, dmem_we, dmem_ack, dmem_err;
  logic       ir_load, rf_rd_en, alu_en, cc_load, rf_we_e, rf_we_m, pc_we;
  logic [1:0] pc_sel;
  logic [2:0] stat;
  logic       halted;
`ifdef Y86_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  y86_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .cnd(cnd),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .ir_load(ir_load), .rf_rd_en(rf_rd_en), .alu_en(alu_en), .cc_load(cc_load),
    .rf_we_e(rf_we_e), .rf_we_m(rf_we_m), .pc_we(pc_we), .pc_sel(pc_sel),
    .stat(stat), .halted(halted)
`ifdef Y86_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  function automatic logic [11:0] ctl_vec();
    return {imem_req, dmem_req, dmem_we, ir_load, rf_rd_en, alu_en,
            cc_load, rf_we_e, rf_we_m, pc_we, pc_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one instruction from FETCH through PCUPDATE with an acking responder and records what it saw.
  task automatic exec_instr(input logic [3:0] ic, input logic c, input int dwait,
                            output int cyc, output logic [1:0] sel,
                            output logic we_e, output logic we_m, output logic dwe,
                            output logic mem, output logic cc, output logic ir);
    int mc = 0;
    cyc = -1; sel = 2'd3; we_e = 0; we_m = 0; dwe = 0; mem = 0; cc = 0; ir = 0;
    icode = ic; cnd = c;
    for (int n = 1; n <= 40; n++) begin
      imem_ack = imem_req; imem_err = 1'b0;
      dmem_ack = dmem_req && (mc == dwait); dmem_err = 1'b0;
      #1;
      if (ir_load) ir = 1'b1;
      if (cc_load) cc = 1'b1;
      if (rf_we_e) we_e = 1'b1;
      if (rf_we_m) we_m = 1'b1;
      if (dmem_req) begin
        mem = 1'b1; dwe = dmem_we; mc++;
      end
      if (pc_we) begin
        sel = pc_sel; cyc = n;
        break;
      end
      tick();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; icode = 4'h1; cnd = 1'b0;
    imem_ack = 1'b1; imem_err = 1'b0; dmem_ack = 1'b1; dmem_err = 1'b0;
    tick(); tick();
    #1;
    total++;
    if (ctl_vec() !== 12'd0) begin bad++; $display("FAIL reset_ctl: got %h want 000", ctl_vec()); end
    total++;
    if (stat !== 3'd1 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_stat: stat=%0d halted=%b want 1/0", stat, halted);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_no_req: imem_req=%b want 0", imem_req); end
    tick();
    total++;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL fetch_after_boot: imem_req=%b want 1", imem_req); end
  endtask

  task automatic test_nops();
    int cyc; logic [1:0] sel; logic e, m, dwe, mem, cc, ir;
    for (int k = 0; k < 3; k++) begin
      exec_instr(4'h1, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
      total++;
      if (cyc !== 5 || sel !== 2'd0 || ir !== 1'b1 || mem !== 1'b0) begin
        bad++; $display("FAIL nop%0d: cyc=%0d sel=%0d ir=%b mem=%b want 5/0/1/0", k, cyc, sel, ir, mem);
      end
    end
    total++;
    if (stat !== 3'd1 || halted !== 1'b0) begin bad++; $display("FAIL nop_stat: stat=%0d want 1", stat); end
  endtask

  task automatic test_memory_ops();
    int cyc; logic [1:0] sel; logic e, m, dwe, mem, cc, ir;
    exec_instr(4'h5, 1'b0, 2, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (cyc !== 8 || dwe !== 1'b0 || m !== 1'b1 || e !== 1'b0 || sel !== 2'd0) begin
      bad++; $display("FAIL mrmovl: cyc=%0d we=%b wm=%b we_e=%b sel=%0d want 8/0/1/0/0", cyc, dwe, m, e, sel);
    end
    exec_instr(4'h4, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (cyc !== 6 || dwe !== 1'b1 || m !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL rmmovl: cyc=%0d we=%b wm=%b we_e=%b want 6/1/0/0", cyc, dwe, m, e);
    end
    exec_instr(4'h5, 1'b0, 3, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (cyc !== 9 || stat !== 3'd1 || halted !== 1'b0) begin
      bad++; $display("FAIL ack_at_limit: cyc=%0d stat=%0d want 9/1", cyc, stat);
    end
  endtask

  task automatic test_alu_cmov();
    int cyc; logic [1:0] sel; logic e, m, dwe, mem, cc, ir;
    exec_instr(4'h6, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (cyc !== 5 || cc !== 1'b1 || e !== 1'b1 || m !== 1'b0) begin
      bad++; $display("FAIL opl: cyc=%0d cc=%b we_e=%b wm=%b want 5/1/1/0", cyc, cc, e, m);
    end
    exec_instr(4'h3, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (cc !== 1'b0 || e !== 1'b1) begin bad++; $display("FAIL irmovl: cc=%b we_e=%b want 0/1", cc, e); end
    exec_instr(4'h2, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL cmov_nc: we_e=%b want 0", e); end
    exec_instr(4'h2, 1'b1, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL cmov_c: we_e=%b want 1", e); end
  endtask

  task automatic test_pc_select();
    int cyc; logic [1:0] sel; logic e, m, dwe, mem, cc, ir;
    exec_instr(4'h7, 1'b1, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (sel !== 2'd1 || cyc !== 5) begin bad++; $display("FAIL jxx_taken: sel=%0d cyc=%0d want 1/5", sel, cyc); end
    exec_instr(4'h7, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (sel !== 2'd0) begin bad++; $display("FAIL jxx_not: sel=%0d want 0", sel); end
    exec_instr(4'h9, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (sel !== 2'd2 || dwe !== 1'b0 || mem !== 1'b1 || e !== 1'b1) begin
      bad++; $display("FAIL ret: sel=%0d we=%b mem=%b we_e=%b want 2/0/1/1", sel, dwe, mem, e);
    end
    exec_instr(4'h8, 1'b0, 0, cyc, sel, e, m, dwe, mem, cc, ir);
    total++;
    if (sel !== 2'd1 || dwe !== 1'b1 || cyc !== 6) begin
      bad++; $display("FAIL call: sel=%0d we=%b cyc=%0d want 1/1/6", sel, dwe, cyc);
    end
  endtask

  task automatic test_bad_icode(input logic [3:0] ic, input logic [2:0] want);
    int pcw = 0;
    icode = ic; cnd = 1'b0;
    imem_ack = 1'b1; imem_err = 1'b0;
    #1;
    tick();
    imem_ack = 1'b0;
    #1;
    total++;
    if (rf_rd_en !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL decode_%0h: rd=%b halted=%b want 1/0", ic, rf_rd_en, halted);
    end
    tick();
    total++;
    if (stat !== want || halted !== 1'b1) begin
      bad++; $display("FAIL halt_%0h: stat=%0d halted=%b want %0d/1", ic, stat, halted, want);
    end
    for (int n = 0; n < 6; n++) begin
      if (pc_we || imem_req || rf_rd_en) pcw++;
      tick();
    end
    total++;
    if (pcw !== 0) begin bad++; $display("FAIL halt_quiet_%0h: active=%0d want 0", ic, pcw); end
    do_reset();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int busy = 0;
    icode = 4'h5; cnd = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    for (int n = 0; n < 10 && !halted; n++) begin
      if (dmem_req) reqs++;
      tick();
    end
    #1;
    total++;
    if (reqs !== 4 || stat !== 3'd3 || halted !== 1'b1 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL timeout: reqs=%0d stat=%0d halted=%b req=%b want 4/3/1/0", reqs, stat, halted, dmem_req);
    end
    dmem_ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      if (rf_we_m || pc_we || stat != 3'd3) busy++;
      tick();
    end
    dmem_ack = 1'b0;
    total++;
    if (busy !== 0) begin bad++; $display("FAIL late_ack: active=%0d want 0", busy); end
    do_reset();
  endtask

  task automatic test_fetch_err();
    icode = 4'h1;
    imem_ack = 1'b1; imem_err = 1'b1;
    #1;
    total++;
    if (ir_load !== 1'b0) begin bad++; $display("FAIL ferr_irload: ir_load=%b want 0", ir_load); end
    tick();
    imem_ack = 1'b0; imem_err = 1'b0;
    total++;
    if (stat !== 3'd3 || halted !== 1'b1) begin
      bad++; $display("FAIL fetch_err: stat=%0d halted=%b want 3/1", stat, halted);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    icode = 4'h4; cnd = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick(); tick(); tick();
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      bad++; $display("FAIL mem_wait: req=%b we=%b want 1/1", dmem_req, dmem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctl_vec() !== 12'd0 || stat !== 3'd1 || halted !== 1'b0) begin
      bad++; $display("FAIL async_reset: ctl=%h stat=%0d halted=%b want 000/1/0", ctl_vec(), stat, halted);
    end
`ifdef Y86_PERF_CNT_EN
    total++;
    if (retired_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      bad++; $display("FAIL perf_reset: retired=%0d cycles=%0d want 0/0", retired_cnt, cycle_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reboot: imem_req=%b want 0", imem_req); end
    tick();
    total++;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL refetch: imem_req=%b want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_memory_ops();
    test_alu_cmov();
    test_pc_select();
    test_bad_icode(4'hC, 3'd4);
    test_bad_icode(4'h0, 3'd2);
    test_timeout();
    test_fetch_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
